// File: rtl/dram_ctrl_pkg.sv
// Shared encodings, scheduler states and default geometry for the DRAM command scheduler.
package dram_ctrl_pkg;

  localparam int DEF_BANKS       = 8;
  localparam int DEF_ROWS        = 128;
  localparam int DEF_COLS        = 8;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ACK_TIMEOUT = 64;

  localparam int DEF_BW = $clog2(DEF_BANKS);
  localparam int DEF_RW = $clog2(DEF_ROWS);
  localparam int DEF_CW = $clog2(DEF_COLS);

  typedef enum logic [1:0] {
    CMD_ACT = 2'b00,
    CMD_RD  = 2'b01,
    CMD_WR  = 2'b10,
    CMD_PRE = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    PRE_REQ,
    PRE_REL,
    ACT_REQ,
    ACT_REL,
    RW_REQ,
    RW_REL
  } state_e;

endpackage

// File: rtl/dram_cmd_sched_if.sv
// L2-request, DRAM-command and read-response signals of the scheduler; master = scheduler side.
interface dram_cmd_sched_if
  import dram_ctrl_pkg::*;
#(
  parameter int NUM_OF_BANKS = DEF_BANKS,
  parameter int NUM_OF_ROWS  = DEF_ROWS,
  parameter int NUM_OF_COLS  = DEF_COLS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH
);
  localparam int BW = $clog2(NUM_OF_BANKS);
  localparam int RW = $clog2(NUM_OF_ROWS);
  localparam int CW = $clog2(NUM_OF_COLS);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr;
  logic [BW-1:0]           req_bank;
  logic [RW-1:0]           req_row;
  logic [CW-1:0]           req_col;
  logic [DATA_WIDTH-1:0]   req_data;
  logic                    cmd_req;
  logic [1:0]              cmd;
  logic                    cmd_ack;
  logic [BW-1:0]           bank_id;
  logic [RW-1:0]           row_id;
  logic [CW-1:0]           col_id;
  logic [NUM_OF_BANKS-1:0] bank_sel;
  logic [NUM_OF_ROWS-1:0]  row_sel;
  logic [NUM_OF_COLS-1:0]  col_sel;
  logic                    bank_rw;
  logic                    buf_rw;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   dram_dout;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    err;

  modport master (
    input  req_valid, req_wr, req_bank, req_row, req_col, req_data, cmd_ack, dram_dout,
    output req_ready, cmd_req, cmd, bank_id, row_id, col_id, bank_sel, row_sel, col_sel,
           bank_rw, buf_rw, wr_data, rsp_valid, rsp_data, err
  );

  modport slave (
    output req_valid, req_wr, req_bank, req_row, req_col, req_data, cmd_ack, dram_dout,
    input  req_ready, cmd_req, cmd, bank_id, row_id, col_id, bank_sel, row_sel, col_sel,
           bank_rw, buf_rw, wr_data, rsp_valid, rsp_data, err
  );
endinterface

// File: rtl/dram_open_row_table.sv
// Per-bank open-row tracking: valid bit plus open row id, with combinational lookup.
module dram_open_row_table
  import dram_ctrl_pkg::*;
#(
  parameter int NUM_OF_BANKS = DEF_BANKS,
  parameter int NUM_OF_ROWS  = DEF_ROWS
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] lk_bank,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  lk_row,
  output logic                            lk_open,
  output logic                            lk_hit,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  lk_open_row,
  input  logic                            set_en,
  input  logic                            clr_en,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] upd_bank,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  upd_row
);
  localparam int RW = $clog2(NUM_OF_ROWS);

  logic [NUM_OF_BANKS-1:0] vld_q, vld_d;
  logic [RW-1:0]           row_q [NUM_OF_BANKS];
  logic [RW-1:0]           row_d [NUM_OF_BANKS];

  always_comb begin
    vld_d = vld_q;
    row_d = row_q;
    if (clr_en) vld_d[upd_bank] = 1'b0;
    if (set_en) begin
      vld_d[upd_bank] = 1'b1;
      row_d[upd_bank] = upd_row;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      vld_q <= '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) row_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      row_q <= row_d;
    end
  end

  assign lk_open     = vld_q[lk_bank];
  assign lk_open_row = row_q[lk_bank];
  assign lk_hit      = vld_q[lk_bank] && (row_q[lk_bank] == lk_row);
endmodule

// File: rtl/dram_cmd_sched.sv
// Open-page DRAM command scheduler: issues PRE/ACT/RD/WR over a four-phase req/ack handshake.
module dram_cmd_sched
  import dram_ctrl_pkg::*;
#(
  parameter int NUM_OF_BANKS = DEF_BANKS,
  parameter int NUM_OF_ROWS  = DEF_ROWS,
  parameter int NUM_OF_COLS  = DEF_COLS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
  input logic              clk,
  input logic              rst_b,
  dram_cmd_sched_if.master bus
);
  localparam int BW = $clog2(NUM_OF_BANKS);
  localparam int RW = $clog2(NUM_OF_ROWS);
  localparam int CW = $clog2(NUM_OF_COLS);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic                    ack_s1_q, ack_s2_q;
  logic                    accept;
  logic                    wr_q, wr_d;
  logic [BW-1:0]           bank_q, bank_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic                    req_ready_q, req_ready_d;
  logic                    cmd_req_q, cmd_req_d;
  cmd_e                    cmd_q, cmd_d;
  logic [BW-1:0]           bank_id_q, bank_id_d;
  logic [RW-1:0]           row_id_q, row_id_d;
  logic [CW-1:0]           col_id_q, col_id_d;
  logic [NUM_OF_BANKS-1:0] bank_sel_q, bank_sel_d;
  logic [NUM_OF_ROWS-1:0]  row_sel_q, row_sel_d;
  logic [NUM_OF_COLS-1:0]  col_sel_q, col_sel_d;
  logic                    bank_rw_q, bank_rw_d;
  logic                    buf_rw_q, buf_rw_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    err_q, err_d;
  logic                    tbl_set, tbl_clr, lk_open, lk_hit, active;
  logic [RW-1:0]           lk_open_row;

  // Request fields are taken straight from the bus in the accept cycle so lookup and decode see them.
  assign accept = bus.req_valid && req_ready_q;
  assign wr_d   = accept ? bus.req_wr   : wr_q;
  assign bank_d = accept ? bus.req_bank : bank_q;
  assign row_d  = accept ? bus.req_row  : row_q;
  assign col_d  = accept ? bus.req_col  : col_q;
  assign data_d = accept ? bus.req_data : data_q;

  dram_open_row_table #(.NUM_OF_BANKS(NUM_OF_BANKS), .NUM_OF_ROWS(NUM_OF_ROWS)) u_tbl (
    .clk(clk), .rst_b(rst_b),
    .lk_bank(bank_d), .lk_row(row_d), .lk_open(lk_open), .lk_hit(lk_hit), .lk_open_row(lk_open_row),
    .set_en(tbl_set), .clr_en(tbl_clr), .upd_bank(bank_q), .upd_row(row_q)
  );

  always_comb begin
    state_d     = state_q;
    tbl_set     = 1'b0;
    tbl_clr     = 1'b0;
    rsp_valid_d = 1'b0;
    err_d       = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE:    if (accept) state_d = lk_hit ? RW_REQ : (lk_open ? PRE_REQ : ACT_REQ);
      PRE_REQ: if (ack_s2_q) state_d = PRE_REL;
      PRE_REL: if (!ack_s2_q) begin tbl_clr = 1'b1; state_d = ACT_REQ; end
      ACT_REQ: if (ack_s2_q) state_d = ACT_REL;
      ACT_REL: if (!ack_s2_q) begin tbl_set = 1'b1; state_d = RW_REQ; end
      RW_REQ:  if (ack_s2_q) begin
                 state_d = RW_REL;
                 if (!wr_q) rsp_data_d = bus.dram_dout;
               end
      RW_REL:  if (!ack_s2_q) begin rsp_valid_d = !wr_q; state_d = IDLE; end
      default: state_d = IDLE;
    endcase
    // A stalled handshake abandons the request and forgets the bank's row, whatever else happened.
    if (state_q != IDLE && tmo_q == TMO_LAST) begin
      state_d     = IDLE;
      err_d       = 1'b1;
      tbl_set     = 1'b0;
      tbl_clr     = 1'b1;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
    end
    tmo_d = (state_d != state_q || state_q == IDLE) ? '0 : tmo_q + 1'b1;

    active      = (state_d != IDLE);
    req_ready_d = !active;
    cmd_req_d   = (state_d == PRE_REQ) || (state_d == ACT_REQ) || (state_d == RW_REQ);
    case (state_d)
      PRE_REQ, PRE_REL: cmd_d = CMD_PRE;
      RW_REQ, RW_REL:   cmd_d = wr_d ? CMD_WR : CMD_RD;
      default:          cmd_d = CMD_ACT;
    endcase
    bank_rw_d  = (cmd_d == CMD_PRE) && active;
    buf_rw_d   = (cmd_d == CMD_WR) && active;
    bank_id_d  = active ? bank_d : '0;
    row_id_d   = !active ? '0 : (bank_rw_d ? lk_open_row : row_d);
    col_id_d   = active ? col_d : '0;
    bank_sel_d = active ? ({{(NUM_OF_BANKS-1){1'b0}}, 1'b1} << bank_id_d) : '0;
    row_sel_d  = active ? ({{(NUM_OF_ROWS-1){1'b0}}, 1'b1} << row_id_d) : '0;
    col_sel_d  = active ? ({{(NUM_OF_COLS-1){1'b0}}, 1'b1} << col_id_d) : '0;
    wr_data_d  = buf_rw_d ? data_d : '0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;   ack_s1_q <= 1'b0;  ack_s2_q <= 1'b0;
      wr_q <= 1'b0;      bank_q <= '0;      row_q <= '0;      col_q <= '0;
      data_q <= '0;      tmo_q <= '0;       req_ready_q <= 1'b0;
      cmd_req_q <= 1'b0; cmd_q <= CMD_ACT;  bank_id_q <= '0;  row_id_q <= '0;
      col_id_q <= '0;    bank_sel_q <= '0;  row_sel_q <= '0;  col_sel_q <= '0;
      bank_rw_q <= 1'b0; buf_rw_q <= 1'b0;  wr_data_q <= '0;
      rsp_valid_q <= 1'b0; rsp_data_q <= '0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;     ack_s1_q <= bus.cmd_ack; ack_s2_q <= ack_s1_q;
      wr_q <= wr_d;           bank_q <= bank_d;        row_q <= row_d;     col_q <= col_d;
      data_q <= data_d;       tmo_q <= tmo_d;          req_ready_q <= req_ready_d;
      cmd_req_q <= cmd_req_d; cmd_q <= cmd_d;          bank_id_q <= bank_id_d; row_id_q <= row_id_d;
      col_id_q <= col_id_d;   bank_sel_q <= bank_sel_d; row_sel_q <= row_sel_d; col_sel_q <= col_sel_d;
      bank_rw_q <= bank_rw_d; buf_rw_q <= buf_rw_d;    wr_data_q <= wr_data_d;
      rsp_valid_q <= rsp_valid_d; rsp_data_q <= rsp_data_d; err_q <= err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.cmd_req   = cmd_req_q;
  assign bus.cmd       = cmd_q;
  assign bus.bank_id   = bank_id_q;
  assign bus.row_id    = row_id_q;
  assign bus.col_id    = col_id_q;
  assign bus.bank_sel  = bank_sel_q;
  assign bus.row_sel   = row_sel_q;
  assign bus.col_sel   = col_sel_q;
  assign bus.bank_rw   = bank_rw_q;
  assign bus.buf_rw    = buf_rw_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_dram_cmd_sched.sv
// Directed bench for dram_cmd_sched: the initial block plays both the L2 requester and the DRAM acknowledger.
module tb_dram_cmd_sched;
  import dram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  dram_cmd_sched_if bus ();
  dram_cmd_sched dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  int compares = 0;
  int mismatches = 0;
  int cyc = 0;
  int cmd_cnt = 0, rsp_cnt = 0, err_cnt = 0;
  int c0 = 0, r0 = 0, t0 = 0;
  logic [7:0] last_rsp = '0;
  logic prev_req = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cmd_req && !prev_req) cmd_cnt <= cmd_cnt + 1;
    prev_req <= bus.cmd_req;
    if (bus.rsp_valid) begin
      rsp_cnt  <= rsp_cnt + 1;
      last_rsp <= bus.rsp_data;
    end
    if (bus.err) err_cnt <= err_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compares++;
    assert (obs === exp) else begin
      mismatches++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic val, input string tag);
    int n = 0;
    while (bus.cmd_req !== val && n < 300) begin @(negedge clk); n++; end
    chk({tag, ".wait_cmd_req"}, bus.cmd_req, val);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk({tag, ".wait_ready"}, bus.req_ready, 1'b1);
  endtask

  task automatic send_req(input logic wr, input int bank, input int row, input int col, input logic [7:0] d);
    wait_ready("send");
    c0 = cmd_cnt; r0 = rsp_cnt; t0 = cyc;
    bus.req_valid = 1'b1; bus.req_wr = wr;
    bus.req_bank = 3'(bank); bus.req_row = 7'(row); bus.req_col = 3'(col); bus.req_data = d;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Wait for one command, check what is presented, then complete the four-phase handshake.
  task automatic do_cmd(input string tag, input logic [1:0] ecmd, input int bank, input int row,
                        input int col, input logic [7:0] d);
    logic [127:0] one;
    wait_req(1'b1, tag);
    one = 128'd1;
    chk({tag, ".cmd"}, bus.cmd, ecmd);
    chk({tag, ".bank_id"}, bus.bank_id, bank);
    chk({tag, ".bank_sel"}, bus.bank_sel, one << bank);
    chk({tag, ".row_id"}, bus.row_id, row);
    chk({tag, ".row_sel"}, bus.row_sel, one << row);
    chk({tag, ".bank_rw"}, bus.bank_rw, ecmd == CMD_PRE);
    chk({tag, ".buf_rw"}, bus.buf_rw, ecmd == CMD_WR);
    if (ecmd == CMD_RD || ecmd == CMD_WR) begin
      chk({tag, ".col_id"}, bus.col_id, col);
      chk({tag, ".col_sel"}, bus.col_sel, one << col);
    end
    if (ecmd == CMD_WR) chk({tag, ".wr_data"}, bus.wr_data, d);
    bus.dram_dout = d;
    bus.cmd_ack = 1'b1;
    wait_req(1'b0, tag);
    bus.cmd_ack = 1'b0;
  endtask

  task automatic end_txn(input string tag, input int ncmd, input int nrsp);
    wait_ready(tag);
    repeat (2) @(negedge clk);
    chk({tag, ".ncmd"}, cmd_cnt - c0, ncmd);
    chk({tag, ".nrsp"}, rsp_cnt - r0, nrsp);
  endtask

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_bank = '0; bus.req_row = '0;
    bus.req_col = '0; bus.req_data = '0; bus.cmd_ack = 1'b0; bus.dram_dout = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.req_ready", bus.req_ready, 1'b0);
    chk("rst.cmd_req", bus.cmd_req, 1'b0);
    chk("rst.bank_sel", bus.bank_sel, 0);
    chk("rst.rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst.err", bus.err, 1'b0);
    rst_b = 1'b1;
    wait_ready("rst");

    // Closed-bank write: ACT then WR, fixed latency with an immediate responder
    send_req(1'b1, 2, 5, 3, 8'hA5);
    do_cmd("wr.act", CMD_ACT, 2, 5, 3, 8'h00);
    do_cmd("wr.wr", CMD_WR, 2, 5, 3, 8'hA5);
    wait_ready("wr");
    chk("wr.latency", cyc - t0, 13);
    chk("wr.idle_sel", bus.bank_sel, 0);
    chk("wr.idle_req", bus.cmd_req, 1'b0);
    end_txn("wr", 2, 0);

    // Row hit read
    send_req(1'b0, 2, 5, 3, 8'h00);
    do_cmd("hit.rd", CMD_RD, 2, 5, 3, 8'hA5);
    end_txn("hit", 1, 1);
    chk("hit.rsp_data", last_rsp, 8'hA5);
    chk("hit.rsp_hold", bus.rsp_data, 8'hA5);

    // Row miss: PRE presents the old row, ACT the new one
    send_req(1'b0, 2, 9, 6, 8'h00);
    do_cmd("miss.pre", CMD_PRE, 2, 5, 6, 8'h00);
    do_cmd("miss.act", CMD_ACT, 2, 9, 6, 8'h00);
    do_cmd("miss.rd", CMD_RD, 2, 9, 6, 8'h3C);
    end_txn("miss", 3, 1);
    chk("miss.rsp_data", last_rsp, 8'h3C);
    send_req(1'b0, 2, 9, 1, 8'h00);
    do_cmd("miss2.rd", CMD_RD, 2, 9, 1, 8'h77);
    end_txn("miss2", 1, 1);
    chk("miss2.rsp_data", last_rsp, 8'h77);

    // Bank independence
    send_req(1'b1, 0, 1, 2, 8'h5C);
    do_cmd("ind0.act", CMD_ACT, 0, 1, 2, 8'h00);
    do_cmd("ind0.wr", CMD_WR, 0, 1, 2, 8'h5C);
    end_txn("ind0", 2, 0);
    send_req(1'b0, 7, 1, 4, 8'h00);
    do_cmd("ind7.act", CMD_ACT, 7, 1, 4, 8'h00);
    do_cmd("ind7.rd", CMD_RD, 7, 1, 4, 8'h12);
    end_txn("ind7", 2, 1);
    send_req(1'b0, 0, 1, 2, 8'h00);
    do_cmd("ind0b.rd", CMD_RD, 0, 1, 2, 8'h5C);
    end_txn("ind0b", 1, 1);
    chk("ind0b.rsp_data", last_rsp, 8'h5C);

    // Timeout on ACT_REQ: no ack ever arrives
    send_req(1'b1, 5, 2, 0, 8'h11);
    wait_req(1'b1, "tmo");
    chk("tmo.cmd", bus.cmd, CMD_ACT);
    n = 0;
    while (bus.err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("tmo.err", bus.err, 1'b1);
    chk("tmo.cycles", n, 64);
    chk("tmo.cmd_req", bus.cmd_req, 1'b0);
    chk("tmo.req_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    chk("tmo.err_pulse", bus.err, 1'b0);
    end_txn("tmo", 1, 0);

    // Timeout on a row-hit RD invalidates that bank's entry
    send_req(1'b0, 2, 9, 0, 8'h00);
    wait_req(1'b1, "tmo2");
    chk("tmo2.cmd", bus.cmd, CMD_RD);
    n = 0;
    while (bus.err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("tmo2.err", bus.err, 1'b1);
    end_txn("tmo2", 1, 0);
    send_req(1'b0, 2, 9, 0, 8'h00);
    do_cmd("tmo2b.act", CMD_ACT, 2, 9, 0, 8'h00);
    do_cmd("tmo2b.rd", CMD_RD, 2, 9, 0, 8'h99);
    end_txn("tmo2b", 2, 1);
    chk("tmo2b.rsp_data", last_rsp, 8'h99);
    chk("tmo.err_total", err_cnt, 2);

    // Reset while WR_REQ is waiting for ack
    send_req(1'b1, 3, 4, 1, 8'h5A);
    do_cmd("rstw.act", CMD_ACT, 3, 4, 1, 8'h00);
    wait_req(1'b1, "rstw");
    chk("rstw.cmd", bus.cmd, CMD_WR);
    rst_b = 1'b0;
    #1;
    chk("rstw.cmd_req", bus.cmd_req, 1'b0);
    chk("rstw.buf_rw", bus.buf_rw, 1'b0);
    chk("rstw.req_ready", bus.req_ready, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    send_req(1'b1, 3, 4, 1, 8'h5A);
    do_cmd("rstw2.act", CMD_ACT, 3, 4, 1, 8'h00);
    do_cmd("rstw2.wr", CMD_WR, 3, 4, 1, 8'h5A);
    end_txn("rstw2", 2, 0);
    send_req(1'b0, 0, 1, 2, 8'h00);
    do_cmd("rstw3.act", CMD_ACT, 0, 1, 2, 8'h00);
    do_cmd("rstw3.rd", CMD_RD, 0, 1, 2, 8'h44);
    end_txn("rstw3", 2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end
endmodule
